otter_mem_arbiter: RTL and testbench

OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

---
 rtl/otter_mem_arbiter_if.sv | 57 +++++
 rtl/otter_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_otter_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the two requesters (M0 = CPU data port, M1 = DMA/loader),
// the arbiter and the byte-addressable memory data port.
//   slave  : arbiter side (samples requests and memory read data, drives grants,
//            read returns, memory port and conflict counter)
//   master : environment side (requesters plus memory model)
interface otter_mem_arbiter_if;
    // Requester 0
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_din;
    logic        m0_we;
    logic [1:0]  m0_size;
    logic        m0_sign;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    // Requester 1
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_din;
    logic        m1_we;
    logic [1:0]  m1_size;
    logic        m1_sign;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    // Memory data port
    logic [31:0] mem_addr2;
    logic [31:0] mem_din2;
    logic        mem_write2;
    logic        mem_read2;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout2;
    // Status
    logic [15:0] conflict_cnt;

    modport slave (
        input  m0_req, m0_addr, m0_din, m0_we, m0_size, m0_sign,
        input  m1_req, m1_addr, m1_din, m1_we, m1_size, m1_sign,
        input  mem_dout2,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign,
        output conflict_cnt
    );

    modport master (
        output m0_req, m0_addr, m0_din, m0_we, m0_size, m0_sign,
        output m1_req, m1_addr, m1_din, m1_we, m1_size, m1_sign,
        output mem_dout2,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign,
        input  conflict_cnt
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Two-requester round-robin arbiter for the OTTER memory data port.
// Writes take one cycle; reads take two (grant cycle + one read-wait cycle in
// which the held address/size/sign are replayed and the read data returned).
// Ports:
//   mem_clk : sole clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : otter_mem_arbiter_if.slave (requests, grants, read returns,
//             memory drive, saturating conflict counter)
// Parameter:
//   RR_INIT : requester treated as last-served after reset (0 -> M1 wins first tie)
module otter_mem_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input logic                  mem_clk,
    input logic                  rst_n,
    otter_mem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StRdWait} state_e;

    state_e      state_q;
    logic        owner_q;
    logic        last_q;
    logic [31:0] a_addr_q;
    logic [1:0]  a_size_q;
    logic        a_sign_q;
    logic [15:0] cnt_q;

    logic        any_req;
    logic        win;       // 1 selects M1
    logic        grant;
    logic        gnt0;
    logic        gnt1;
    logic        deny;
    logic [31:0] w_addr;
    logic [31:0] w_din;
    logic        w_we;
    logic [1:0]  w_size;
    logic        w_sign;

    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        // On a tie the requester that was not served last wins.
        win     = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
        // Grants are forced low while reset is held, even with requests present.
        grant   = (state_q == StIdle) & any_req & rst_n;
        gnt0    = grant & ~win;
        gnt1    = grant & win;
        deny    = (bus.m0_req & ~gnt0) | (bus.m1_req & ~gnt1);

        w_addr  = win ? bus.m1_addr : bus.m0_addr;
        w_din   = win ? bus.m1_din  : bus.m0_din;
        w_we    = win ? bus.m1_we   : bus.m0_we;
        w_size  = win ? bus.m1_size : bus.m0_size;
        w_sign  = win ? bus.m1_sign : bus.m0_sign;
    end

    always_comb begin
        bus.m0_gnt     = gnt0;
        bus.m1_gnt     = gnt1;
        bus.mem_addr2  = a_addr_q;
        bus.mem_size   = a_size_q;
        bus.mem_sign   = a_sign_q;
        bus.mem_din2   = 32'h0;
        bus.mem_write2 = 1'b0;
        bus.mem_read2  = 1'b0;
        bus.m0_rvalid  = 1'b0;
        bus.m1_rvalid  = 1'b0;
        bus.m0_rdata   = 32'h0;
        bus.m1_rdata   = 32'h0;
        bus.conflict_cnt = cnt_q;

        if (grant) begin
            bus.mem_addr2  = w_addr;
            bus.mem_din2   = w_din;
            bus.mem_size   = w_size;
            bus.mem_sign   = w_sign;
            bus.mem_write2 = w_we;
            bus.mem_read2  = ~w_we;
        end

        // Memory holds the slice valid while addr/size/sign are replayed from the
        // held registers, so the return is a straight pass-through.
        if (state_q == StRdWait) begin
            if (owner_q) begin
                bus.m1_rvalid = 1'b1;
                bus.m1_rdata  = bus.mem_dout2;
            end else begin
                bus.m0_rvalid = 1'b1;
                bus.m0_rdata  = bus.mem_dout2;
            end
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= RR_INIT;
            a_addr_q <= 32'h0;
            a_size_q <= 2'b00;
            a_sign_q <= 1'b0;
            cnt_q    <= 16'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        a_addr_q <= w_addr;
                        a_size_q <= w_size;
                        a_sign_q <= w_sign;
                        owner_q  <= win;
                        last_q   <= win;
                        if (!w_we) begin
                            state_q <= StRdWait;
                        end
                    end
                end
                StRdWait: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // One increment per cycle with any denial, saturating at all-ones.
            if (deny && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: scenario tasks with inline checks,
// read-return scoreboard queues per requester, and a simple memory slice model.
module tb_otter_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    otter_mem_arbiter_if bus ();

    otter_mem_arbiter #(.RR_INIT(1'b0)) dut (
        .mem_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_words [0:255];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        pend0 = 1'b0;
    logic        pend1 = 1'b0;
    logic [31:0] exp0;
    logic [31:0] exp1;

    // Memory model: little-endian byte/half/word slice at the presented address.
    logic [31:0] mw;
    logic [31:0] msh;
    always_comb begin
        mw  = mem_words[bus.mem_addr2[9:2]];
        msh = mw >> {bus.mem_addr2[1:0], 3'b000};
        case (bus.mem_size)
            2'd0:    bus.mem_dout2 = bus.mem_sign ? {{24{msh[7]}}, msh[7:0]}
                                                  : {24'h0, msh[7:0]};
            2'd1:    bus.mem_dout2 = bus.mem_sign ? {{16{msh[15]}}, msh[15:0]}
                                                  : {16'h0, msh[15:0]};
            default: bus.mem_dout2 = mw;
        endcase
    end

    // Read-return monitor: RVALID must follow a read grant by exactly one cycle,
    // carry the next scoreboard entry, and RDATA must be zero otherwise.
    always @(negedge clk) begin
        checks++;
        if (bus.m0_rvalid !== (pend0 && rst_n)) begin
            errors++;
            $display("FAIL rvalid_timing_m0 got=%b exp=%b", bus.m0_rvalid, pend0 && rst_n);
        end
        if (bus.m0_rvalid === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid_m0 got=1 exp=0");
            end else begin
                exp0 = q0.pop_front();
                if (bus.m0_rdata !== exp0) begin
                    errors++;
                    $display("FAIL rdata_m0 got=%h exp=%h", bus.m0_rdata, exp0);
                end
            end
        end else begin
            checks++;
            if (bus.m0_rdata !== 32'h0) begin
                errors++;
                $display("FAIL rdata_idle_m0 got=%h exp=0", bus.m0_rdata);
            end
        end
        checks++;
        if (bus.m1_rvalid !== (pend1 && rst_n)) begin
            errors++;
            $display("FAIL rvalid_timing_m1 got=%b exp=%b", bus.m1_rvalid, pend1 && rst_n);
        end
        if (bus.m1_rvalid === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid_m1 got=1 exp=0");
            end else begin
                exp1 = q1.pop_front();
                if (bus.m1_rdata !== exp1) begin
                    errors++;
                    $display("FAIL rdata_m1 got=%h exp=%h", bus.m1_rdata, exp1);
                end
            end
        end else begin
            checks++;
            if (bus.m1_rdata !== 32'h0) begin
                errors++;
                $display("FAIL rdata_idle_m1 got=%h exp=0", bus.m1_rdata);
            end
        end
        pend0 = (bus.m0_gnt === 1'b1) && (bus.mem_read2 === 1'b1);
        pend1 = (bus.m1_gnt === 1'b1) && (bus.mem_read2 === 1'b1);
    end

    task automatic drive(input bit m, input logic req, input logic [31:0] addr,
                         input logic [31:0] din, input logic we, input logic [1:0] size,
                         input logic sign);
        if (!m) begin
            bus.m0_req = req; bus.m0_addr = addr; bus.m0_din = din;
            bus.m0_we = we; bus.m0_size = size; bus.m0_sign = sign;
        end else begin
            bus.m1_req = req; bus.m1_addr = addr; bus.m1_din = din;
            bus.m1_we = we; bus.m1_size = size; bus.m1_sign = sign;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Requests held high during reset must not be granted or counted.
        drive(0, 1, 32'h40, 32'h1, 1, 2'd2, 0);
        drive(1, 1, 32'h44, 32'h2, 1, 2'd2, 0);
        @(negedge clk);
        checks++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt_m0 got=%b exp=0", bus.m0_gnt); end
        checks++; if (bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt_m1 got=%b exp=0", bus.m1_gnt); end
        checks++; if (bus.mem_write2 !== 1'b0) begin errors++; $display("FAIL rst_write got=%b exp=0", bus.mem_write2); end
        checks++; if (bus.mem_read2 !== 1'b0) begin errors++; $display("FAIL rst_read got=%b exp=0", bus.mem_read2); end
        checks++; if (bus.conflict_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got=%h exp=0", bus.conflict_cnt); end
        checks++; if (bus.mem_addr2 !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr2); end
        step();
        checks++; if (bus.conflict_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt_hold got=%h exp=0", bus.conflict_cnt); end
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        // Issued in the first cycle after reset release.
        drive(0, 1, 32'h100, 32'h0, 0, 2'd2, 0);
        @(negedge clk);
        checks++; if (bus.m0_gnt !== 1'b1) begin errors++; $display("FAIL sr_gnt_m0 got=%b exp=1", bus.m0_gnt); end
        checks++; if (bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL sr_gnt_m1 got=%b exp=0", bus.m1_gnt); end
        checks++; if (bus.mem_read2 !== 1'b1) begin errors++; $display("FAIL sr_read got=%b exp=1", bus.mem_read2); end
        checks++; if (bus.mem_write2 !== 1'b0) begin errors++; $display("FAIL sr_write got=%b exp=0", bus.mem_write2); end
        checks++; if (bus.mem_addr2 !== 32'h100) begin errors++; $display("FAIL sr_addr0 got=%h exp=100", bus.mem_addr2); end
        q0.push_back(32'hDEADBEEF);
        step();
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        @(negedge clk);
        checks++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL sr_wait_gnt got=%b exp=0", bus.m0_gnt); end
        checks++; if (bus.mem_read2 !== 1'b0) begin errors++; $display("FAIL sr_wait_read got=%b exp=0", bus.mem_read2); end
        checks++; if (bus.mem_addr2 !== 32'h100) begin errors++; $display("FAIL sr_addr1 got=%h exp=100", bus.mem_addr2); end
        checks++; if (bus.m0_rvalid !== 1'b1) begin errors++; $display("FAIL sr_rvalid got=%b exp=1", bus.m0_rvalid); end
        checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata got=%h exp=deadbeef", bus.m0_rdata); end
        step();
    endtask

    task automatic test_conflict();
        do_reset();
        drive(0, 1, 32'h11000004, 32'h0A0A0A0A, 1, 2'd2, 0);
        drive(1, 1, 32'h300, 32'h5555AAAA, 1, 2'd1, 1);
        @(negedge clk);
        checks++; if (bus.m1_gnt !== 1'b1) begin errors++; $display("FAIL cf_gnt_m1 got=%b exp=1", bus.m1_gnt); end
        checks++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL cf_gnt_m0 got=%b exp=0", bus.m0_gnt); end
        checks++; if (bus.mem_write2 !== 1'b1) begin errors++; $display("FAIL cf_write got=%b exp=1", bus.mem_write2); end
        checks++; if (bus.mem_addr2 !== 32'h300) begin errors++; $display("FAIL cf_addr1 got=%h exp=300", bus.mem_addr2); end
        checks++; if (bus.mem_din2 !== 32'h5555AAAA) begin errors++; $display("FAIL cf_din1 got=%h exp=5555aaaa", bus.mem_din2); end
        checks++; if ({bus.mem_size, bus.mem_sign} !== 3'b011) begin errors++; $display("FAIL cf_attr1 got=%b exp=011", {bus.mem_size, bus.mem_sign}); end
        step();
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        @(negedge clk);
        checks++; if (bus.m0_gnt !== 1'b1) begin errors++; $display("FAIL cf_gnt_m0_next got=%b exp=1", bus.m0_gnt); end
        checks++; if (bus.mem_addr2 !== 32'h11000004) begin errors++; $display("FAIL cf_addr0 got=%h exp=11000004", bus.mem_addr2); end
        checks++; if (bus.mem_din2 !== 32'h0A0A0A0A) begin errors++; $display("FAIL cf_din0 got=%h exp=0a0a0a0a", bus.mem_din2); end
        step();
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        @(negedge clk);
        checks++; if (bus.conflict_cnt !== 16'd1) begin errors++; $display("FAIL cf_cnt got=%h exp=1", bus.conflict_cnt); end
        checks++; if (bus.mem_din2 !== 32'h0) begin errors++; $display("FAIL cf_idle_din got=%h exp=0", bus.mem_din2); end
        checks++; if (bus.mem_addr2 !== 32'h11000004) begin errors++; $display("FAIL cf_idle_addr got=%h exp=11000004", bus.mem_addr2); end
        checks++; if ({bus.mem_read2, bus.mem_write2} !== 2'b00) begin errors++; $display("FAIL cf_idle_rw got=%b exp=00", {bus.mem_read2, bus.mem_write2}); end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(0, 1, 32'h100, 32'h0, 0, 2'd2, 0);
        drive(1, 1, 32'h304, 32'h12345678, 1, 2'd2, 0);
        for (int k = 0; k < 9; k++) begin
            logic e0, e1;
            e1 = (k % 3 == 0);
            e0 = (k % 3 == 1);
            @(negedge clk);
            checks++; if (bus.m0_gnt !== e0) begin errors++; $display("FAIL b2b_gnt_m0 k=%0d got=%b exp=%b", k, bus.m0_gnt, e0); end
            checks++; if (bus.m1_gnt !== e1) begin errors++; $display("FAIL b2b_gnt_m1 k=%0d got=%b exp=%b", k, bus.m1_gnt, e1); end
            checks++; if (bus.conflict_cnt !== 16'(k)) begin errors++; $display("FAIL b2b_cnt k=%0d got=%h exp=%h", k, bus.conflict_cnt, k); end
            if (e0) q0.push_back(32'hDEADBEEF);
            if (k % 3 == 2) begin
                checks++; if ({bus.mem_read2, bus.mem_write2} !== 2'b00) begin errors++; $display("FAIL b2b_wait_rw k=%0d got=%b exp=00", k, {bus.mem_read2, bus.mem_write2}); end
            end
            step();
        end
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        step();
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL b2b_missing_rvalid got=%0d exp=0", q0.size()); end
    endtask

    task automatic test_byte_read();
        for (int s = 0; s < 2; s++) begin
            logic        sg;
            logic [31:0] ex;
            sg = s[0];
            ex = sg ? 32'hFFFFFFA5 : 32'h000000A5;
            drive(1, 1, 32'h203, 32'h0, 0, 2'd0, sg);
            @(negedge clk);
            checks++; if (bus.m1_gnt !== 1'b1) begin errors++; $display("FAIL br_gnt_m1 s=%0d got=%b exp=1", s, bus.m1_gnt); end
            checks++; if (bus.mem_read2 !== 1'b1) begin errors++; $display("FAIL br_read s=%0d got=%b exp=1", s, bus.mem_read2); end
            q1.push_back(ex);
            step();
            // Change the attributes after grant; the port must replay the held ones.
            drive(1, 0, 32'h0, 32'h0, 0, 2'd2, ~sg);
            @(negedge clk);
            checks++; if (bus.mem_addr2 !== 32'h203) begin errors++; $display("FAIL br_addr s=%0d got=%h exp=203", s, bus.mem_addr2); end
            checks++; if ({bus.mem_size, bus.mem_sign} !== {2'd0, sg}) begin errors++; $display("FAIL br_attr s=%0d got=%b exp=%b", s, {bus.mem_size, bus.mem_sign}, {2'd0, sg}); end
            checks++; if (bus.m1_rdata !== ex) begin errors++; $display("FAIL br_rdata s=%0d got=%h exp=%h", s, bus.m1_rdata, ex); end
            checks++; if (bus.m0_rvalid !== 1'b0) begin errors++; $display("FAIL br_rvalid_m0 s=%0d got=%b exp=0", s, bus.m0_rvalid); end
            step();
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        drive(0, 1, 32'h10, 32'h1, 1, 2'd2, 0);
        drive(1, 1, 32'h14, 32'h2, 1, 2'd2, 0);
        step();
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        step();
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        drive(1, 1, 32'h100, 32'h0, 0, 2'd2, 0);
        @(negedge clk);
        checks++; if (bus.m1_gnt !== 1'b1) begin errors++; $display("FAIL rmr_gnt_m1 got=%b exp=1", bus.m1_gnt); end
        step();
        // Now in the read-wait cycle: abort it.
        rst_n = 1'b0;
        drive(0, 1, 32'h20, 32'h3, 1, 2'd2, 0);
        @(negedge clk);
        checks++; if (bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_rvalid_m1 got=%b exp=0", bus.m1_rvalid); end
        checks++; if (bus.conflict_cnt !== 16'h0) begin errors++; $display("FAIL rmr_cnt got=%h exp=0", bus.conflict_cnt); end
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin errors++; $display("FAIL rmr_gnt got=%b exp=00", {bus.m0_gnt, bus.m1_gnt}); end
        step();
        rst_n = 1'b1;
        drive(1, 1, 32'h24, 32'h4, 1, 2'd2, 0);
        @(negedge clk);
        checks++; if (bus.m1_gnt !== 1'b1) begin errors++; $display("FAIL rmr_first_m1 got=%b exp=1", bus.m1_gnt); end
        checks++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL rmr_first_m0 got=%b exp=0", bus.m0_gnt); end
        checks++; if (bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_late_rvalid got=%b exp=0", bus.m1_rvalid); end
        step();
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(0, 1, 32'h30, 32'h5, 1, 2'd2, 0);
        drive(1, 1, 32'h34, 32'h6, 1, 2'd2, 0);
        for (int k = 0; k < 70000; k++) begin
            if (k == 0 || k == 65534 || k == 65535 || k == 69999) begin
                logic [15:0] ec;
                ec = (k < 65535) ? 16'(k) : 16'hFFFF;
                @(negedge clk);
                checks++; if (bus.conflict_cnt !== ec) begin errors++; $display("FAIL sat_cnt k=%0d got=%h exp=%h", k, bus.conflict_cnt, ec); end
            end
            step();
        end
        checks++; if (bus.conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final got=%h exp=ffff", bus.conflict_cnt); end
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
        mem_words[8'h40] = 32'hDEADBEEF;   // byte address 0x100
        mem_words[8'h80] = 32'hA5112233;   // byte address 0x200
        drive(0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
        drive(1, 0, 32'h0, 32'h0, 0, 2'd0, 0);

        test_reset();
        test_single_read();
        test_conflict();
        test_back_to_back();
        test_byte_read();
        test_reset_mid_read();
        test_saturation();

        checks++;
        if ((q0.size() + q1.size()) != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
